// File: rtl/pxs_ball_pkg.sv
// pxs_ball_pkg: stream field positions, screen geometry, colours and mode encoding
package pxs_ball_pkg;
  localparam int STR_W   = 26;
  localparam int A_BIT   = 0;
  localparam int VS_BIT  = 1;
  localparam int HS_BIT  = 2;
  localparam int YC_LSB  = 3;
  localparam int YC_MSB  = 12;
  localparam int XC_LSB  = 13;
  localparam int XC_MSB  = 22;
  localparam int B_BIT   = 23;
  localparam int G_BIT   = 24;
  localparam int R_BIT   = 25;
  localparam int RGB_LSB = B_BIT;
  localparam int RGB_MSB = R_BIT;
  localparam int VGA_LSB = VS_BIT;
  localparam int VGA_MSB = R_BIT;
  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int LINE_W  = 6;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  typedef enum logic {PLAY = 1'b0, SERVE = 1'b1} mode_e;
endpackage

// File: rtl/pxs_ball_motion.sv
// pxs_ball_motion: per-frame ball position, bounce, goal detection and serve pause
// Ports: px_clk/reset, xc/yc current input pixel coordinates; bx/by ball top-left,
// visible (ball drawn), goal_l/goal_r one-cycle goal pulses.
// Optional PXS_BALL_PAUSE_EN: hides and freezes the ball for SERVE_FRAMES frames after a goal.
module pxs_ball_motion
  import pxs_ball_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int SPEED_X = 2,
  parameter int SPEED_Y = 2
`ifdef PXS_BALL_PAUSE_EN
  , parameter int SERVE_FRAMES = 60
`endif
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic [9:0] xc,
  input  logic [9:0] yc,
  output logic [9:0] bx,
  output logic [9:0] by,
  output logic       visible,
  output logic       goal_l,
  output logic       goal_r
);
  localparam logic [10:0] SX    = 11'(SPEED_X);
  localparam logic [10:0] SY    = 11'(SPEED_Y);
  localparam logic [10:0] X_MAX = 11'(SCR_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX = 11'(SCR_H - LINE_W - BALL_SIZE);
  localparam logic [10:0] Y_MIN = 11'(LINE_W);
  localparam logic [9:0]  CX    = 10'((SCR_W - BALL_SIZE) / 2);
  localparam logic [9:0]  CY    = 10'((SCR_H - BALL_SIZE) / 2);
  logic [9:0] bx_q, bx_d, by_q, by_d;
  logic dir_x_q, dir_x_d, dir_y_q, dir_y_d, goal_l_q, goal_l_d, goal_r_q, goal_r_d;
  logic tick, move, bounce_lo, bounce_hi;
  logic [10:0] sum_x, dif_x, sum_y, dif_y;
  assign tick = xc == 10'd0 && yc == 10'(SCR_H);
  assign move = tick && visible;
  assign bx = bx_q;
  assign by = by_q;
  assign goal_l = goal_l_q;
  assign goal_r = goal_r_q;
  always_comb begin
    sum_x = {1'b0, bx_q} + SX;
    dif_x = {1'b0, bx_q} - SX;
    sum_y = {1'b0, by_q} + SY;
    dif_y = {1'b0, by_q} - SY;
    bounce_hi = sum_y > Y_MAX;
    bounce_lo = {1'b0, by_q} < Y_MIN + SY;
    goal_r_d = move && dir_x_q && sum_x > X_MAX;
    goal_l_d = move && !dir_x_q && {1'b0, bx_q} < SX;
    bx_d = bx_q;
    by_d = by_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (goal_l_d || goal_r_d) begin
      bx_d = CX;
      by_d = CY;
      dir_x_d = !dir_x_q;
    end else if (move) begin
      bx_d = dir_x_q ? sum_x[9:0] : dif_x[9:0];
      by_d = dir_y_q ? (bounce_hi ? Y_MAX[9:0] : sum_y[9:0]) : (bounce_lo ? Y_MIN[9:0] : dif_y[9:0]);
      dir_y_d = dir_y_q ? !bounce_hi : bounce_lo;
    end
  end
  always_ff @(posedge px_clk) begin
    if (reset) begin
      bx_q <= CX;
      by_q <= CY;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      goal_l_q <= goal_l_d;
      goal_r_q <= goal_r_d;
    end
  end
`ifdef PXS_BALL_PAUSE_EN
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  mode_e mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign visible = mode_q == PLAY;
  // the last serve tick hands back to PLAY so the ball moves again on the following frame
  always_comb begin
    mode_d = mode_q;
    cnt_d = cnt_q;
    if (goal_l_d || goal_r_d) begin
      mode_d = SERVE;
      cnt_d = CW'(SERVE_FRAMES);
    end else if (tick && mode_q == SERVE) begin
      mode_d = cnt_q == CW'(1) ? PLAY : SERVE;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge px_clk) begin
    if (reset) begin
      mode_q <= PLAY;
      cnt_q <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign visible = 1'b1;
`endif
endmodule

// File: rtl/pxs_ball.sv
// pxs_ball: overlays the moving ball on the court RGB stream with one cycle of latency
// Ports: px_clk/reset; RGBStr_i/RGBStr_o 26-bit stream {RGB[25:23], XC[22:13], YC[12:3], HS, VS, Active};
// goal_l/goal_r one-cycle goal pulses. Optional PXS_BALL_PAUSE_EN enables the serve pause.
module pxs_ball
  import pxs_ball_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int SPEED_X = 2,
  parameter int SPEED_Y = 2
`ifdef PXS_BALL_PAUSE_EN
  , parameter int SERVE_FRAMES = 60
`endif
) (
  input  logic             px_clk,
  input  logic             reset,
  input  logic [STR_W-1:0] RGBStr_i,
  output logic [STR_W-1:0] RGBStr_o,
  output logic             goal_l,
  output logic             goal_r
);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  logic [9:0] xc, yc, bx, by;
  logic visible, hit;
  logic [STR_W-1:0] str_q, str_d;
  assign xc = RGBStr_i[XC_MSB:XC_LSB];
  assign yc = RGBStr_i[YC_MSB:YC_LSB];
  assign RGBStr_o = str_q;
  pxs_ball_motion #(
    .BALL_SIZE(BALL_SIZE),
    .SPEED_X(SPEED_X),
    .SPEED_Y(SPEED_Y)
`ifdef PXS_BALL_PAUSE_EN
    , .SERVE_FRAMES(SERVE_FRAMES)
`endif
  ) u_motion (
    .px_clk(px_clk),
    .reset(reset),
    .xc(xc),
    .yc(yc),
    .bx(bx),
    .by(by),
    .visible(visible),
    .goal_l(goal_l),
    .goal_r(goal_r)
  );
  always_comb begin
    hit = RGBStr_i[A_BIT] && visible
       && xc >= bx && {1'b0, xc} < {1'b0, bx} + BS
       && yc >= by && {1'b0, yc} < {1'b0, by} + BS;
    str_d = {hit ? WHITE : RGBStr_i[RGB_MSB:RGB_LSB], RGBStr_i[RGB_LSB-1:0]};
  end
  always_ff @(posedge px_clk) str_q <= reset ? '0 : str_d;
endmodule

// File: tb/tb_pxs_ball.sv
// tb_pxs_ball: randomized pixel/tick stimulus checked against a frame-level ball model
module tb_pxs_ball;
  logic px_clk = 1'b0;
  logic reset = 1'b1;
  logic [25:0] RGBStr_i = '0;
  logic [25:0] RGBStr_o;
  logic goal_l, goal_r;
  int total = 0, bad = 0;
  int mbx, mby, mcnt;
  bit mdx, mdy, mserve;
  logic [25:0] exp_str;
  bit exp_gl, exp_gr;
  localparam int SF = 60;

  pxs_ball dut (
    .px_clk(px_clk),
    .reset(reset),
    .RGBStr_i(RGBStr_i),
    .RGBStr_o(RGBStr_o),
    .goal_l(goal_l),
    .goal_r(goal_r)
  );

  always #5 px_clk = ~px_clk;

  task automatic model_reset();
    mbx = 316; mby = 236; mdx = 1; mdy = 1; mserve = 0; mcnt = 0;
  endtask

  task automatic model_tick();
    int nx, ny;
    bit ndy;
    if (mserve) begin
      if (mcnt == 1) begin mserve = 0; mcnt = 0; end
      else mcnt--;
      return;
    end
    ndy = mdy;
    ny = mdy ? mby + 2 : mby - 2;
    if (ny > 466) begin ny = 466; ndy = 0; end
    else if (ny < 6) begin ny = 6; ndy = 1; end
    nx = mdx ? mbx + 2 : mbx - 2;
    if (nx > 632 || nx < 0) begin
      exp_gr = nx > 632;
      exp_gl = nx < 0;
      mbx = 316; mby = 236; mdx = !mdx;
`ifdef PXS_BALL_PAUSE_EN
      mserve = 1; mcnt = SF;
`endif
    end else begin
      mbx = nx; mby = ny; mdy = ndy;
    end
  endtask

  // drive one pixel, predict the registered output, advance one clock
  task automatic step(input bit rst, input int x, input int y, input bit act);
    logic [22:0] low;
    logic [2:0] rgb;
    logic [1:0] sync;
    bit hit;
    sync = 2'($urandom);
    rgb = 3'($urandom);
    low = {10'(x), 10'(y), sync, act};
    RGBStr_i = {rgb, low};
    hit = act && !mserve && x >= mbx && x < mbx + 8 && y >= mby && y < mby + 8;
    exp_str = rst ? 26'd0 : {hit ? 3'b111 : rgb, low};
    exp_gl = 0;
    exp_gr = 0;
    if (rst) model_reset();
    else if (x == 0 && y == 480) model_tick();
    reset = rst;
    @(posedge px_clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 316, 236, 1);
      total++;
      if (RGBStr_o !== 26'd0) begin bad++; $display("FAIL reset_str: got %h expected %h", RGBStr_o, 26'd0); end
      total++;
      if ({goal_l, goal_r} !== 2'b00) begin bad++; $display("FAIL reset_goal: got %b expected 00", {goal_l, goal_r}); end
    end
  endtask

  task automatic test_draw();
    for (int y = 234; y <= 245; y++)
      for (int x = 313; x <= 326; x++) begin
        step(0, x, y, 1);
        total++;
        if (RGBStr_o !== exp_str) begin bad++; $display("FAIL draw(%0d,%0d): got %h expected %h", x, y, RGBStr_o, exp_str); end
      end
  endtask

  task automatic test_inactive();
    for (int x = 314; x <= 325; x++) begin
      step(0, x, 238, 0);
      total++;
      if (RGBStr_o !== exp_str) begin bad++; $display("FAIL inactive(%0d): got %h expected %h", x, RGBStr_o, exp_str); end
    end
  endtask

  // ticks until the ball bounces off the bottom line, probing its box edges each frame
  task automatic test_bounce();
    for (int i = 0; i < 300 && mdy; i++) begin
      step(0, 0, 480, 1);
      total++;
      if ({goal_l, goal_r} !== {exp_gl, exp_gr}) begin bad++; $display("FAIL bounce_goal: got %b expected %b", {goal_l, goal_r}, {exp_gl, exp_gr}); end
      for (int d = 7; d <= 8; d++) begin
        step(0, mbx + d, mby + d, 1);
        total++;
        if (RGBStr_o !== exp_str) begin bad++; $display("FAIL bounce_draw: got %h expected %h", RGBStr_o, exp_str); end
      end
    end
    total++;
    if (mdy || mby != 466) begin bad++; $display("FAIL bounce_reach: got by=%0d dir_y=%0d expected by=466 dir_y=0", mby, mdy); end
    for (int y = 472; y <= 475; y++) begin
      step(0, mbx + 1, y, 1);
      total++;
      if (RGBStr_o !== exp_str) begin bad++; $display("FAIL bottom_draw(%0d): got %h expected %h", y, RGBStr_o, exp_str); end
    end
  endtask

  task automatic test_goal();
    int seen_l = 0, seen_r = 0;
    for (int i = 0; i < 600 && seen_l == 0; i++) begin
      step(0, 0, 480, 0);
      total++;
      if ({goal_l, goal_r} !== {exp_gl, exp_gr}) begin bad++; $display("FAIL goal_pulse: got %b expected %b", {goal_l, goal_r}, {exp_gl, exp_gr}); end
      seen_l += int'(goal_l);
      seen_r += int'(goal_r);
      step(0, 316 + (i % 8), 236 + (i % 8), 1);
      total++;
      if (RGBStr_o !== exp_str) begin bad++; $display("FAIL goal_draw: got %h expected %h", RGBStr_o, exp_str); end
      total++;
      if ({goal_l, goal_r} !== 2'b00) begin bad++; $display("FAIL goal_width: got %b expected 00", {goal_l, goal_r}); end
    end
    total++;
    if (seen_r != 1 || seen_l != 1) begin bad++; $display("FAIL goal_count: got r=%0d l=%0d expected r=1 l=1", seen_r, seen_l); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      int x, y, r;
      r = int'($urandom_range(0, 19));
      x = mbx - 4 + int'($urandom_range(0, 15));
      y = mby - 4 + int'($urandom_range(0, 15));
      if (x < 0) x = 0;
      if (r == 0) begin x = 0; y = 480; end
      else if (r == 1) begin x = int'($urandom_range(1, 1023)); y = 480; end
      step(0, x, y, bit'($urandom_range(0, 3) != 0));
      total++;
      if (RGBStr_o !== exp_str) begin bad++; $display("FAIL random_str: got %h expected %h", RGBStr_o, exp_str); end
      total++;
      if ({goal_l, goal_r} !== {exp_gl, exp_gr}) begin bad++; $display("FAIL random_goal: got %b expected %b", {goal_l, goal_r}, {exp_gl, exp_gr}); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 100 && (mbx == 316 || mserve); i++) step(0, 0, 480, 0);
    step(0, 100, 200, 1);
    step(1, 101, 200, 1);
    total++;
    if (RGBStr_o !== 26'd0 || {goal_l, goal_r} !== 2'b00) begin bad++; $display("FAIL mid_reset: got %h/%b expected 0/00", RGBStr_o, {goal_l, goal_r}); end
    for (int x = 315; x <= 324; x++) begin
      step(0, x, 236, 1);
      total++;
      if (RGBStr_o !== exp_str) begin bad++; $display("FAIL mid_reset_draw(%0d): got %h expected %h", x, RGBStr_o, exp_str); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_draw();
    test_inactive();
    test_bounce();
    test_goal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
